// File: rtl/amp_coeff_mac.sv
// amp_coeff_mac: per-band input gain stage, coefficient selector and
// multiply-accumulate filter core for a multi-band FIR bank. An external
// counter walks the tap index. phase_min marks tap 0 of each frame: at that
// edge the finished sum is published and the accumulator restarts.
module amp_coeff_mac #(
    parameter int FILTER_IN_BITS    = 16,
    parameter int FILTER_OUT_BITS   = 16,
    parameter int NUMBER_OF_FILTERS = 8,
    parameter int GAIN_BITS         = 2,
    parameter int GAIN_FRAC_BITS    = 0,
    parameter int NUMBER_OF_TAPS    = 64,
    parameter int COUNTER_BITS      = 6,
    parameter int COEFF_BITS        = 16,
    parameter int COEFF_FRAC_BITS   = 16
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 clk_enable,
    input  logic                                                 amplifier_enable,
    input  logic [NUMBER_OF_FILTERS*GAIN_BITS-1:0]               amplifier_gains,
    input  logic signed [FILTER_IN_BITS-1:0]                     filter_in,
    output logic [NUMBER_OF_FILTERS*FILTER_IN_BITS-1:0]          amplified_filter_ins,
    input  logic [COUNTER_BITS-1:0]                              current_count,
    input  logic                                                 phase_min,
    input  logic [NUMBER_OF_FILTERS*FILTER_IN_BITS-1:0]          delay_filter_ins,
    input  logic [NUMBER_OF_FILTERS*NUMBER_OF_TAPS*COEFF_BITS-1:0] coeffs,
    output logic [NUMBER_OF_FILTERS*FILTER_OUT_BITS-1:0]         filtered_outs
);

    // Gain product: signed sample times zero-extended unsigned gain.
    localparam int AMP_BITS     = FILTER_IN_BITS + GAIN_BITS + 1;
    // Full-precision sample x coefficient product.
    localparam int PROD_BITS    = FILTER_IN_BITS + COEFF_BITS;
    // Headroom for summing every tap of a frame without wrap-around.
    localparam int ACC_BITS     = PROD_BITS + $clog2(NUMBER_OF_TAPS);
    localparam int TAP_IDX_BITS = (NUMBER_OF_TAPS > 1) ? $clog2(NUMBER_OF_TAPS) : 1;

    localparam logic signed [AMP_BITS-1:0] AMP_MAX =
        {{(AMP_BITS-FILTER_IN_BITS+1){1'b0}}, {(FILTER_IN_BITS-1){1'b1}}};
    localparam logic signed [AMP_BITS-1:0] AMP_MIN =
        {{(AMP_BITS-FILTER_IN_BITS+1){1'b1}}, {(FILTER_IN_BITS-1){1'b0}}};
    localparam logic signed [ACC_BITS-1:0] OUT_MAX =
        {{(ACC_BITS-FILTER_OUT_BITS+1){1'b0}}, {(FILTER_OUT_BITS-1){1'b1}}};
    localparam logic signed [ACC_BITS-1:0] OUT_MIN =
        {{(ACC_BITS-FILTER_OUT_BITS+1){1'b1}}, {(FILTER_OUT_BITS-1){1'b0}}};

    // Clamp a scaled gain product into the input sample range.
    function automatic logic signed [FILTER_IN_BITS-1:0] sat_amp(
        input logic signed [AMP_BITS-1:0] v
    );
        logic signed [FILTER_IN_BITS-1:0] r;
        if (v > AMP_MAX) begin
            r = AMP_MAX[FILTER_IN_BITS-1:0];
        end else if (v < AMP_MIN) begin
            r = AMP_MIN[FILTER_IN_BITS-1:0];
        end else begin
            r = v[FILTER_IN_BITS-1:0];
        end
        return r;
    endfunction

    // Clamp a shifted accumulator value into the output sample range.
    function automatic logic signed [FILTER_OUT_BITS-1:0] sat_out(
        input logic signed [ACC_BITS-1:0] v
    );
        logic signed [FILTER_OUT_BITS-1:0] r;
        if (v > OUT_MAX) begin
            r = OUT_MAX[FILTER_OUT_BITS-1:0];
        end else if (v < OUT_MIN) begin
            r = OUT_MIN[FILTER_OUT_BITS-1:0];
        end else begin
            r = v[FILTER_OUT_BITS-1:0];
        end
        return r;
    endfunction

    for (genvar g = 0; g < NUMBER_OF_FILTERS; g++) begin : g_band
        logic        [GAIN_BITS-1:0]       gain_s;
        logic signed [AMP_BITS-1:0]        amp_prod_s;
        logic signed [AMP_BITS-1:0]        amp_shift_s;
        logic signed [FILTER_IN_BITS-1:0]  amp_s;
        logic        [COEFF_BITS-1:0]      band_taps_s [NUMBER_OF_TAPS];
        logic        [TAP_IDX_BITS-1:0]    tap_idx_s;
        logic signed [COEFF_BITS-1:0]      coeff_s;
        logic signed [FILTER_IN_BITS-1:0]  delay_s;
        logic signed [PROD_BITS-1:0]       product_s;
        logic signed [ACC_BITS-1:0]        acc_r;
        logic signed [ACC_BITS-1:0]        acc_shift_s;
        logic signed [FILTER_OUT_BITS-1:0] out_r;

        assign gain_s      = amplifier_gains[g*GAIN_BITS +: GAIN_BITS];
        assign amp_prod_s  = AMP_BITS'(filter_in) * AMP_BITS'($signed({1'b0, gain_s}));
        assign amp_shift_s = amp_prod_s >>> GAIN_FRAC_BITS;

        // Gain stage: bypass passes the raw sample, otherwise scaled and clamped.
        always_comb begin
            amp_s = filter_in;
            if (amplifier_enable) begin
                amp_s = sat_amp(amp_shift_s);
            end else begin
                amp_s = filter_in;
            end
        end

        assign amplified_filter_ins[g*FILTER_IN_BITS +: FILTER_IN_BITS] = amp_s;

        for (genvar t = 0; t < NUMBER_OF_TAPS; t++) begin : g_tap
            assign band_taps_s[t] = coeffs[(g*NUMBER_OF_TAPS+t)*COEFF_BITS +: COEFF_BITS];
        end

        assign tap_idx_s = TAP_IDX_BITS'(current_count);

        // Coefficient selector: out-of-range tap indices contribute nothing.
        always_comb begin
            coeff_s = '0;
            if (int'(current_count) < NUMBER_OF_TAPS) begin
                coeff_s = $signed(band_taps_s[tap_idx_s]);
            end else begin
                coeff_s = '0;
            end
        end

        assign delay_s     = $signed(delay_filter_ins[g*FILTER_IN_BITS +: FILTER_IN_BITS]);
        assign product_s   = PROD_BITS'(delay_s) * PROD_BITS'(coeff_s);
        assign acc_shift_s = acc_r >>> COEFF_FRAC_BITS;

        // Accumulate one tap per enabled edge; tap 0 publishes and restarts.
        always_ff @(posedge clk) begin
            if (rst) begin
                acc_r <= '0;
                out_r <= '0;
            end else if (clk_enable) begin
                if (phase_min) begin
                    out_r <= sat_out(acc_shift_s);
                    acc_r <= ACC_BITS'(product_s);
                end else begin
                    acc_r <= acc_r + ACC_BITS'(product_s);
                end
            end else begin
                acc_r <= acc_r;
                out_r <= out_r;
            end
        end

        assign filtered_outs[g*FILTER_OUT_BITS +: FILTER_OUT_BITS] = out_r;
    end

endmodule

// File: tb/tb_amp_coeff_mac.sv
// Self-checking bench for amp_coeff_mac: gain stage, tap selection through
// single-tap frames, full-frame MAC with saturation, stall and reset.
module tb_amp_coeff_mac;
    localparam int FIN  = 16;
    localparam int FOUT = 16;
    localparam int NF   = 8;
    localparam int GB   = 2;
    localparam int GFB  = 0;
    localparam int NT   = 64;
    localparam int CNTB = 6;
    localparam int CB   = 16;
    localparam int CFB  = 16;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      clk_enable;
    logic                      amplifier_enable;
    logic [NF*GB-1:0]          amplifier_gains;
    logic signed [FIN-1:0]     filter_in;
    logic [NF*FIN-1:0]         amplified_filter_ins;
    logic [CNTB-1:0]           current_count;
    logic                      phase_min;
    logic [NF*FIN-1:0]         delay_filter_ins;
    logic [NF*NT*CB-1:0]       coeffs;
    logic [NF*FOUT-1:0]        filtered_outs;

    amp_coeff_mac u_dut (
        .clk                  (clk),
        .rst                  (rst),
        .clk_enable           (clk_enable),
        .amplifier_enable     (amplifier_enable),
        .amplifier_gains      (amplifier_gains),
        .filter_in            (filter_in),
        .amplified_filter_ins (amplified_filter_ins),
        .current_count        (current_count),
        .phase_min            (phase_min),
        .delay_filter_ins     (delay_filter_ins),
        .coeffs               (coeffs),
        .filtered_outs        (filtered_outs)
    );

    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_errors = 0;
    longint exp_q[$];
    longint coeff_mem [NF][NT];
    longint delay_mem [NF][NT];
    longint last_exp  [NF];
    bit     pending;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint sat_model(input longint v, input int bits);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (bits - 1)) - 1;
        lo = -(longint'(1) <<< (bits - 1));
        if (v > hi) return hi;
        else if (v < lo) return lo;
        else return v;
    endfunction

    function automatic longint amp_model(input longint x, input int g, input bit en);
        if (!en) return x;
        return sat_model((x * g) >>> GFB, FIN);
    endfunction

    function automatic longint mac_model(input int b, input int first);
        longint s;
        s = 0;
        for (int t = first; t < NT; t++) s += delay_mem[b][t] * coeff_mem[b][t];
        return sat_model(s >>> CFB, FOUT);
    endfunction

    function automatic longint out_band(input int b);
        logic [FOUT-1:0] v;
        v = filtered_outs[b*FOUT +: FOUT];
        return longint'($signed(v));
    endfunction

    function automatic longint amp_band(input int b);
        logic [FIN-1:0] v;
        v = amplified_filter_ins[b*FIN +: FIN];
        return longint'($signed(v));
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_coeffs();
        for (int b = 0; b < NF; b++)
            for (int t = 0; t < NT; t++)
                coeffs[(b*NT+t)*CB +: CB] = CB'(coeff_mem[b][t]);
    endtask

    task automatic fill_random();
        for (int b = 0; b < NF; b++)
            for (int t = 0; t < NT; t++) begin
                coeff_mem[b][t] = longint'($urandom_range(65535, 0)) - 32768;
                delay_mem[b][t] = longint'($urandom_range(4000, 0)) - 2000;
            end
    endtask

    task automatic publish_check();
        longint e;
        for (int b = 0; b < NF; b++) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_underflow", 0, 1);
            end else begin
                e = exp_q.pop_front();
                check_eq($sformatf("mac_b%0d", b), out_band(b), e);
                last_exp[b] = e;
            end
        end
    endtask

    // One 64-tap frame; optional mid-frame reset and 10-cycle stall.
    task automatic run_frame(input int rst_at, input int stall_at,
                             input bit use_const, input longint b0_const);
        int first;
        first = (rst_at >= 0) ? rst_at + 1 : 0;
        load_coeffs();
        for (int b = 0; b < NF; b++) begin
            if (b == 0 && use_const) exp_q.push_back(b0_const);
            else exp_q.push_back(mac_model(b, first));
        end
        for (int t = 0; t < NT; t++) begin
            if (t == stall_at) begin
                clk_enable = 1'b0;
                for (int k = 0; k < 10; k++) begin
                    current_count    = CNTB'($urandom);
                    phase_min        = k[0];
                    delay_filter_ins = {4{32'($urandom)}};
                    step();
                end
                for (int b = 0; b < NF; b++) check_eq("stall_hold", out_band(b), last_exp[b]);
                clk_enable = 1'b1;
            end
            current_count = CNTB'(t);
            phase_min     = (t == 0);
            rst           = (t == rst_at);
            for (int b = 0; b < NF; b++) delay_filter_ins[b*FIN +: FIN] = FIN'(delay_mem[b][t]);
            step();
            rst = 1'b0;
            if (t == 0 && pending) publish_check();
            if (t == rst_at) begin
                for (int b = 0; b < NF; b++) begin
                    check_eq("rst_mid", out_band(b), 0);
                    last_exp[b] = 0;
                end
            end
            if (t == 40) begin
                check_eq("hold_mid_b0", out_band(0), last_exp[0]);
                check_eq("hold_mid_b5", out_band(5), last_exp[5]);
            end
        end
        pending = 1'b1;
    endtask

    task automatic amp_check(input string tag);
        longint e;
        #1;
        for (int b = 0; b < NF; b++) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_underflow", 0, 1);
            end else begin
                e = exp_q.pop_front();
                check_eq($sformatf("%s_b%0d", tag, b), amp_band(b), e);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; clk_enable = 1'b1; amplifier_enable = 1'b0;
        amplifier_gains = '0; filter_in = '0; current_count = '0;
        phase_min = 1'b0; delay_filter_ins = '0; coeffs = '0;
        pending = 1'b0;
        for (int b = 0; b < NF; b++) last_exp[b] = 0;
        @(negedge clk);
        step();
        step();
        for (int b = 0; b < NF; b++) check_eq("reset_out", out_band(b), 0);
        rst = 1'b0;

        // Amplifier bypass.
        amplifier_enable = 1'b0; filter_in = -16'sd1234; amplifier_gains = 16'($urandom);
        for (int b = 0; b < NF; b++) exp_q.push_back(-1234);
        amp_check("amp_bypass");

        // Gain 3 saturates, gain 1 passes, gain 0 clears.
        amplifier_enable = 1'b1; filter_in = 16'sd20000;
        amplifier_gains = 16'($urandom);
        amplifier_gains[5:0] = 6'b00_01_11;
        exp_q.push_back(32767); exp_q.push_back(20000); exp_q.push_back(0);
        for (int b = 3; b < NF; b++)
            exp_q.push_back(amp_model(20000, int'(amplifier_gains[b*GB +: GB]), 1'b1));
        amp_check("amp_gain");

        filter_in = -16'sd100; amplifier_gains = 16'hAAAA;
        for (int b = 0; b < NF; b++) exp_q.push_back(-200);
        amp_check("amp_neg");

        filter_in = -16'sd30000; amplifier_gains = 16'hFFFF;
        for (int b = 0; b < NF; b++) exp_q.push_back(-32768);
        amp_check("amp_negsat");

        for (int k = 0; k < 4; k++) begin
            filter_in = 16'($urandom); amplifier_gains = 16'($urandom);
            for (int b = 0; b < NF; b++)
                exp_q.push_back(amp_model(longint'(filter_in), int'(amplifier_gains[b*GB +: GB]), 1'b1));
            amp_check("amp_rand");
        end

        // Frame A: band 0 taps 0.25, input 1000 -> 16000.
        fill_random();
        for (int t = 0; t < NT; t++) begin coeff_mem[0][t] = 16384; delay_mem[0][t] = 1000; end
        run_frame(-1, -1, 1'b1, 16000);

        // Frame B / C: positive and negative output saturation.
        fill_random();
        for (int t = 0; t < NT; t++) begin coeff_mem[0][t] = 32767; delay_mem[0][t] = 32767; end
        run_frame(-1, -1, 1'b1, 32767);
        fill_random();
        for (int t = 0; t < NT; t++) begin coeff_mem[0][t] = 32767; delay_mem[0][t] = -32768; end
        run_frame(-1, -1, 1'b1, -32768);

        // Frame D: random with stall; frame E: random with reset at tap 30.
        fill_random();
        run_frame(-1, 20, 1'b0, 0);
        fill_random();
        run_frame(30, -1, 1'b0, 0);

        // Publish the last frame.
        current_count = '0; phase_min = 1'b1; delay_filter_ins = '0;
        step();
        publish_check();
        pending = 1'b0;

        // Single-tap frames select band 1 taps 5 and 63.
        coeff_mem[1][5] = 16'h1234; coeff_mem[1][63] = 16'h0800;
        load_coeffs();
        delay_filter_ins[1*FIN +: FIN] = 16'sd16384;
        current_count = 6'd5; phase_min = 1'b1;
        step();
        current_count = 6'd63;
        step();
        check_eq("tap5_b1", out_band(1), 1165);
        current_count = 6'd0;
        step();
        check_eq("tap63_b1", out_band(1), 512);

        // Reset wins over a disabled clock and leaves the gain stage alone.
        rst = 1'b1; clk_enable = 1'b0; amplifier_enable = 1'b0; filter_in = 16'sd777;
        step();
        for (int b = 0; b < NF; b++) check_eq("reset_noen", out_band(b), 0);
        check_eq("amp_in_reset", amp_band(3), 777);
        rst = 1'b0;
        check_eq("sb_empty", longint'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
